// File: rtl/usb_ep_buf_if.sv
// Core-side transaction bus between the USB protocol core
// and the single-endpoint packet buffer.
interface usb_ep_buf_if;
  logic       transaction_active;
  logic [3:0] endpoint;
  logic       direction_in;
  logic       setup;
  logic       data_toggle;
  logic [1:0] handshake;
  logic [7:0] data_out;
  logic       data_strobe;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       success;

  modport master (
    output transaction_active,
    output endpoint,
    output direction_in,
    output setup,
    output data_out,
    output data_strobe,
    output success,
    input  data_toggle,
    input  handshake,
    input  data_in,
    input  data_in_valid
  );

  modport slave (
    input  transaction_active,
    input  endpoint,
    input  direction_in,
    input  setup,
    input  data_out,
    input  data_strobe,
    input  success,
    output data_toggle,
    output handshake,
    output data_in,
    output data_in_valid
  );
endinterface

// File: rtl/usb_ep_buf.sv
// Single-endpoint USB packet buffer: one OUT and one IN
// packet of MAX_PKT bytes between protocol core and app.
module usb_ep_buf #(
  parameter int EP_NUM  = 0,
  parameter int MAX_PKT = 64,
  localparam int AW = $clog2(MAX_PKT) + 1
) (
  input  logic          clk_48,
  input  logic          rst_n,
  input  logic          usb_rst_i,
  usb_ep_buf_if.slave   core,
  input  logic          stall_req_i,
  output logic          out_pending_o,
  output logic          out_is_setup_o,
  output logic [AW-1:0] out_len_o,
  input  logic          out_rd_en_i,
  output logic [7:0]    out_rd_data_o,
  input  logic          out_release_i,
  input  logic          in_wr_en_i,
  input  logic [7:0]    in_wr_data_i,
  input  logic          in_commit_i,
  output logic          in_busy_o,
  output logic          in_done_o
);

  localparam int IW = AW - 1;
  localparam logic [AW-1:0] FULL = AW'(MAX_PKT);
  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;

  typedef struct packed {
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] len;
    logic          pend;
    logic          is_setup;
    logic          otog;
    logic          itog;
    logic [AW-1:0] in_wptr;
    logic [AW-1:0] in_rptr;
    logic [AW-1:0] in_len;
    logic          busy;
    logic          done;
  } st_t;

  st_t st_q;

  logic [7:0] out_mem [MAX_PKT];
  logic [7:0] in_mem  [MAX_PKT];

  logic          match;
  logic [1:0]    hs;
  logic          out_wr;
  logic          out_ok;
  logic          in_rd;
  logic          in_ok;
  logic          in_wr;
  logic          in_cm;
  logic [AW-1:0] in_wptr_d;

  assign match = core.transaction_active
              && core.endpoint == 4'(EP_NUM);

  always_comb begin
    hs = HS_ACK;
    priority case (1'b1)
      !match:            hs = HS_STALL;
      core.setup:        hs = HS_ACK;
      stall_req_i:       hs = HS_STALL;
      core.direction_in: hs = st_q.busy ? HS_ACK : HS_NAK;
      default:           hs = st_q.pend ? HS_NAK : HS_ACK;
    endcase
  end

  assign out_wr = core.data_strobe && match
               && !core.direction_in && hs == HS_ACK;
  assign out_ok = core.success && match
               && !core.direction_in && hs == HS_ACK;
  assign in_rd  = core.data_strobe && match
               && core.direction_in
               && st_q.in_rptr < st_q.in_len;
  assign in_ok  = core.success && match && core.direction_in
               && !core.setup && hs == HS_ACK;
  assign in_wr  = in_wr_en_i && !st_q.busy
               && st_q.in_wptr != FULL;
  assign in_cm  = in_commit_i && !st_q.busy;
  // commit sees a same-cycle write
  assign in_wptr_d = st_q.in_wptr + AW'(in_wr);

  always_ff @(posedge clk_48) begin
    if (out_wr && st_q.wr_ptr != FULL)
      out_mem[st_q.wr_ptr[IW-1:0]] <= core.data_out;
    if (in_wr)
      in_mem[st_q.in_wptr[IW-1:0]] <= in_wr_data_i;
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else if (usb_rst_i) begin
      st_q <= '0;
    end else begin
      st_q.done <= 1'b0;
      // idle bus rewinds OUT writes and IN reads
      if (!core.transaction_active) begin
        st_q.wr_ptr  <= '0;
        st_q.in_rptr <= '0;
      end else begin
        if (out_wr && st_q.wr_ptr != FULL)
          st_q.wr_ptr <= st_q.wr_ptr + AW'(1);
        if (in_rd)
          st_q.in_rptr <= st_q.in_rptr + AW'(1);
      end
      if (out_rd_en_i && st_q.rd_ptr < st_q.len)
        st_q.rd_ptr <= st_q.rd_ptr + AW'(1);
      if (out_release_i)
        st_q.pend <= 1'b0;
      if (out_ok) begin
        st_q.pend     <= 1'b1;
        st_q.len      <= st_q.wr_ptr;
        st_q.is_setup <= core.setup;
        st_q.rd_ptr   <= '0;
        st_q.wr_ptr   <= '0;
        if (core.setup) begin
          st_q.otog <= 1'b1;
          st_q.itog <= 1'b1;
        end else begin
          st_q.otog <= ~st_q.otog;
        end
      end
      if (in_cm) begin
        st_q.in_len  <= in_wptr_d;
        st_q.busy    <= 1'b1;
        st_q.in_wptr <= '0;
      end else begin
        st_q.in_wptr <= in_wptr_d;
      end
      if (in_ok) begin
        st_q.busy    <= 1'b0;
        st_q.in_rptr <= '0;
        st_q.itog    <= ~st_q.itog;
        st_q.done    <= 1'b1;
      end
    end
  end

  assign core.handshake     = hs;
  assign core.data_toggle   = core.setup ? 1'b0
                            : core.direction_in ? st_q.itog
                            : st_q.otog;
  assign core.data_in       = in_mem[st_q.in_rptr[IW-1:0]];
  assign core.data_in_valid = st_q.busy
                           && st_q.in_rptr < st_q.in_len;

  assign out_pending_o  = st_q.pend;
  assign out_is_setup_o = st_q.is_setup;
  assign out_len_o      = st_q.len;
  assign out_rd_data_o  = out_mem[st_q.rd_ptr[IW-1:0]];
  assign in_busy_o      = st_q.busy;
  assign in_done_o      = st_q.done;

endmodule

// File: tb/tb_usb_ep_buf.sv
// Directed-plus-random bench for usb_ep_buf against a
// queue-based packet model.
module tb_usb_ep_buf;

  localparam int MAXP = 64;
  localparam int AW   = 7;
  localparam logic [1:0] ACK   = 2'b00;
  localparam logic [1:0] NAK   = 2'b10;
  localparam logic [1:0] STALL = 2'b11;

  typedef byte unsigned bq_t[$];

  logic          clk_48 = 1'b0;
  logic          rst_n = 1'b0;
  logic          usb_rst_i = 1'b0;
  logic          stall_req_i = 1'b0;
  logic          out_rd_en_i = 1'b0;
  logic          out_release_i = 1'b0;
  logic          in_wr_en_i = 1'b0;
  logic [7:0]    in_wr_data_i = '0;
  logic          in_commit_i = 1'b0;
  logic          out_pending_o;
  logic          out_is_setup_o;
  logic [AW-1:0] out_len_o;
  logic [7:0]    out_rd_data_o;
  logic          in_busy_o;
  logic          in_done_o;

  int compared = 0;
  int mismatched = 0;

  logic m_pend, m_setup, m_otog, m_itog, m_busy;
  int   m_len;
  bq_t  m_out, m_in, m_arm;

  usb_ep_buf_if bus();

  always #5 clk_48 = ~clk_48;

  usb_ep_buf #(.EP_NUM(0), .MAX_PKT(MAXP)) dut (
    .clk_48         (clk_48),
    .rst_n          (rst_n),
    .usb_rst_i      (usb_rst_i),
    .core           (bus.slave),
    .stall_req_i    (stall_req_i),
    .out_pending_o  (out_pending_o),
    .out_is_setup_o (out_is_setup_o),
    .out_len_o      (out_len_o),
    .out_rd_en_i    (out_rd_en_i),
    .out_rd_data_o  (out_rd_data_o),
    .out_release_i  (out_release_i),
    .in_wr_en_i     (in_wr_en_i),
    .in_wr_data_i   (in_wr_data_i),
    .in_commit_i    (in_commit_i),
    .in_busy_o      (in_busy_o),
    .in_done_o      (in_done_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  function automatic bq_t rnd_q(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_setup = 0; m_otog = 0; m_itog = 0;
    m_busy = 0; m_len = 0;
    m_out.delete(); m_in.delete(); m_arm.delete();
  endtask

  task automatic bus_idle();
    bus.transaction_active = 0;
    bus.endpoint = 4'd0;
    bus.direction_in = 0;
    bus.setup = 0;
    bus.data_out = 8'h00;
    bus.data_strobe = 0;
    bus.success = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pend"}, out_pending_o, m_pend);
    check({tag, "_setup"}, out_is_setup_o, m_setup);
    check({tag, "_len"}, out_len_o, m_len);
    check({tag, "_busy"}, in_busy_o, m_busy);
  endtask

  task automatic do_out(input bit su, input bq_t d,
                        input bit succ);
    logic [1:0] hs;
    bq_t wb;
    bus.transaction_active = 1;
    bus.endpoint = 4'd0;
    bus.direction_in = 0;
    bus.setup = su;
    #1;
    hs = su ? ACK : stall_req_i ? STALL
       : m_pend ? NAK : ACK;
    check("out_hs", bus.handshake, hs);
    check("out_tog", bus.data_toggle, su ? 1'b0 : m_otog);
    foreach (d[i]) begin
      bus.data_out = d[i];
      bus.data_strobe = 1;
      if (hs == ACK && wb.size() < MAXP) wb.push_back(d[i]);
      tick();
    end
    bus.data_strobe = 0;
    if (succ && hs == ACK) begin
      bus.success = 1;
      tick();
      bus.success = 0;
      m_pend = 1; m_setup = su; m_out = wb; m_len = wb.size();
      if (su) begin
        m_otog = 1; m_itog = 1;
      end else begin
        m_otog = ~m_otog;
      end
    end
    bus.transaction_active = 0;
    bus.setup = 0;
    tick();
    check_state("out");
  endtask

  task automatic rd_out();
    foreach (m_out[i]) begin
      check("out_rd", out_rd_data_o, m_out[i]);
      out_rd_en_i = 1;
      tick();
      out_rd_en_i = 0;
    end
  endtask

  task automatic rel_out();
    out_release_i = 1;
    tick();
    out_release_i = 0;
    m_pend = 0;
    check("rel_pend", out_pending_o, m_pend);
  endtask

  task automatic in_load(input bq_t d, input bit cm);
    foreach (d[i]) begin
      in_wr_en_i = 1;
      in_wr_data_i = d[i];
      if (cm && i == d.size() - 1) in_commit_i = 1;
      tick();
    end
    if (d.size() == 0 && cm) begin
      in_commit_i = 1;
      tick();
    end
    in_wr_en_i = 0;
    in_commit_i = 0;
    if (!m_busy) begin
      foreach (d[i]) if (m_in.size() < MAXP) m_in.push_back(d[i]);
      if (cm) begin
        m_arm = m_in; m_in.delete(); m_busy = 1;
      end
    end
    check("load_busy", in_busy_o, m_busy);
    check("load_valid", bus.data_in_valid,
          m_busy && m_arm.size() > 0);
  endtask

  task automatic do_in(input bit succ, input int nmax);
    logic [1:0] hs;
    int n;
    int cnt;
    bus.transaction_active = 1;
    bus.endpoint = 4'd0;
    bus.direction_in = 1;
    bus.setup = 0;
    #1;
    hs = stall_req_i ? STALL : m_busy ? ACK : NAK;
    check("in_hs", bus.handshake, hs);
    check("in_tog", bus.data_toggle, m_itog);
    n = m_busy ? m_arm.size() : 0;
    cnt = n < nmax ? n : nmax;
    for (int i = 0; i < cnt; i++) begin
      check("in_valid", bus.data_in_valid, 1'b1);
      check("in_data", bus.data_in, m_arm[i]);
      bus.data_strobe = 1;
      tick();
      bus.data_strobe = 0;
    end
    check("in_end", bus.data_in_valid, cnt < n);
    if (succ && hs == ACK) begin
      bus.success = 1;
      tick();
      bus.success = 0;
      check("in_done", in_done_o, 1'b1);
      m_busy = 0; m_itog = ~m_itog; m_arm.delete();
    end
    bus.transaction_active = 0;
    bus.direction_in = 0;
    tick();
    check("in_done_clr", in_done_o, 1'b0);
    check("in_busy", in_busy_o, m_busy);
  endtask

  initial begin
    bq_t d;
    bus_idle();
    model_reset();
    repeat (3) tick();
    check("rst_pend", out_pending_o, 1'b0);
    check("rst_busy", in_busy_o, 1'b0);
    rst_n = 1;
    tick();
    check_state("rst");
    check("rst_done", in_done_o, 1'b0);
    check("rst_valid", bus.data_in_valid, 1'b0);
    check("idle_hs", bus.handshake, STALL);

    d = {8'hA1, 8'hB2, 8'hC3};
    do_out(0, d, 1);
    rd_out();
    do_out(0, rnd_q(2), 1);
    rel_out();
    do_out(0, rnd_q(5), 1);

    do_out(1, rnd_q(8), 1);
    rd_out();
    rel_out();
    do_in(0, 0);
    do_out(0, rnd_q(MAXP + 3), 1);
    rd_out();
    rel_out();

    d = {8'h11, 8'h22};
    in_load(d, 1);
    do_in(0, 1);
    do_in(0, 99);
    do_in(1, 99);
    in_load(rnd_q(MAXP + 6), 1);
    in_load(rnd_q(3), 1);
    do_in(1, 99);
    in_load(rnd_q(0), 1);
    do_in(1, 99);

    bus.transaction_active = 1;
    bus.endpoint = 4'd3;
    #1 check("ep_stall", bus.handshake, STALL);
    bus.endpoint = 4'd0;
    stall_req_i = 1;
    #1 check("req_stall", bus.handshake, STALL);
    bus.setup = 1;
    #1 check("setup_ack", bus.handshake, ACK);
    bus_idle();
    stall_req_i = 0;
    tick();

    in_load(rnd_q(3), 1);
    do_out(0, rnd_q(4), 1);
    bus.transaction_active = 1;
    bus.setup = 1;
    bus.data_strobe = 1;
    bus.data_out = 8'h5A;
    tick();
    usb_rst_i = 1;
    tick();
    usb_rst_i = 0;
    bus_idle();
    model_reset();
    tick();
    check_state("urst");
    check("urst_done", in_done_o, 1'b0);
    do_out(0, rnd_q(1), 0);
    do_in(0, 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: do_out(0, rnd_q($urandom_range(0, 70)),
                  1'($urandom_range(0, 1)));
        1: if (m_pend) begin
             rd_out();
             rel_out();
           end
        2: in_load(rnd_q($urandom_range(0, 70)),
                   1'($urandom_range(0, 1)));
        3: do_in(1'($urandom_range(0, 1)),
                 $urandom_range(0, 70));
        default: do_out(1, rnd_q(8), 1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
